// File: rtl/pio_pkg.sv
// Shared encodings for the PIO state-machine core: opcodes, JMP conditions,
// SET/MOV operand codes and the execution state enum.
package pio_pkg;

  localparam logic [2:0] OP_JMP  = 3'b000;
  localparam logic [2:0] OP_WAIT = 3'b001;
  localparam logic [2:0] OP_MOV  = 3'b101;
  localparam logic [2:0] OP_SET  = 3'b111;

  localparam logic [2:0] JC_ALWAYS = 3'b000;
  localparam logic [2:0] JC_X_ZERO = 3'b001;
  localparam logic [2:0] JC_X_DEC  = 3'b010;
  localparam logic [2:0] JC_Y_ZERO = 3'b011;
  localparam logic [2:0] JC_Y_DEC  = 3'b100;
  localparam logic [2:0] JC_X_NE_Y = 3'b101;

  localparam logic [2:0] DST_PINS    = 3'b000;
  localparam logic [2:0] DST_X       = 3'b001;
  localparam logic [2:0] DST_Y       = 3'b010;
  localparam logic [2:0] DST_PINDIRS = 3'b100;

  localparam logic [2:0] SRC_PINS = 3'b000;
  localparam logic [2:0] SRC_X    = 3'b001;
  localparam logic [2:0] SRC_Y    = 3'b010;
  localparam logic [2:0] SRC_NULL = 3'b011;

  localparam logic [1:0] MOP_NONE = 2'b00;
  localparam logic [1:0] MOP_INV  = 2'b01;
  localparam logic [1:0] MOP_REV  = 2'b10;

  typedef enum logic [1:0] {
    ST_EXEC  = 2'b00,
    ST_DELAY = 2'b01,
    ST_WAIT  = 2'b10
  } state_e;

endpackage

// File: rtl/pio_pc_next.sv
// Next program counter: hold, taken jump, wrap-window return, or increment.
module pio_pc_next #(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [ADDR_W-1:0] wrap_top_i,
  input  logic [ADDR_W-1:0] wrap_bottom_i,
  input  logic              jump_taken_i,
  input  logic [ADDR_W-1:0] target_i,
  input  logic              advance_i,
  output logic [ADDR_W-1:0] pc_next_o
);

  // A taken jump bypasses the wrap check entirely
  always_comb begin
    if (!advance_i) begin
      pc_next_o = pc_i;
    end else if (jump_taken_i) begin
      pc_next_o = target_i;
    end else if (pc_i == wrap_top_i) begin
      pc_next_o = wrap_bottom_i;
    end else begin
      pc_next_o = pc_i + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/pio_sm_core.sv
// PIO execution core: fetches one instruction per cycle at pc and executes
// JMP/WAIT/SET/MOV with per-instruction delay and a wrap window.
module pio_sm_core import pio_pkg::*; #(
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32,
  parameter int PIN_W   = 8,
  parameter int DELAY_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              restart,
  input  logic [ADDR_W-1:0] wrap_top,
  input  logic [ADDR_W-1:0] wrap_bottom,
  input  logic [15:0]       instr,
  input  logic [PIN_W-1:0]  pins_in,
  output logic [ADDR_W-1:0] pc,
  output logic [PIN_W-1:0]  pins_out,
  output logic [PIN_W-1:0]  pins_oe,
  output logic              stalled
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d, pc_nxt_s;
  logic [DATA_W-1:0]   x_q, x_d, y_q, y_d;
  logic [PIN_W-1:0]    pins_out_q, pins_out_d, pins_oe_q, pins_oe_d;
  logic [DELAY_W-1:0]  cnt_q, cnt_d;
  logic                stalled_q, stalled_d;

  logic [2:0]          opcode_s, field_s, mov_src_s;
  logic [1:0]          mov_op_s;
  logic [DELAY_W-1:0]  delay_s;
  logic [4:0]          wait_idx_s;
  logic                wait_pin_s, wait_met_s;
  logic [DATA_W-1:0]   mov_src_v_s, mov_rev_s, mov_val_s;
  logic                complete_s, jump_taken_s;

  assign opcode_s   = instr[15:13];
  assign delay_s    = instr[8+DELAY_W-1:8];
  assign field_s    = instr[7:5];
  assign mov_op_s   = instr[4:3];
  assign mov_src_s  = instr[2:0];
  assign wait_idx_s = 5'(32'(instr[4:0]) % PIN_W);
  assign wait_met_s = (wait_pin_s == instr[7]);

  // Select the pin a WAIT is watching (index already reduced mod PIN_W)
  always_comb begin
    wait_pin_s = 1'b0;
    for (int i = 0; i < PIN_W; i++) begin
      wait_pin_s = (32'(wait_idx_s) == i) ? pins_in[i] : wait_pin_s;
    end
  end

  // MOV operand path: source select, then optional invert / bit-reverse
  always_comb begin
    case (mov_src_s)
      SRC_PINS: mov_src_v_s = DATA_W'(pins_in);
      SRC_X:    mov_src_v_s = x_q;
      SRC_Y:    mov_src_v_s = y_q;
      SRC_NULL: mov_src_v_s = '0;
      default:  mov_src_v_s = '0;
    endcase
    for (int i = 0; i < DATA_W; i++) begin
      mov_rev_s[i] = mov_src_v_s[DATA_W-1-i];
    end
    case (mov_op_s)
      MOP_NONE: mov_val_s = mov_src_v_s;
      MOP_INV:  mov_val_s = ~mov_src_v_s;
      MOP_REV:  mov_val_s = mov_rev_s;
      default:  mov_val_s = mov_src_v_s;
    endcase
  end

  pio_pc_next #(.ADDR_W(ADDR_W)) u_pc_next (
    .pc_i          (pc_q),
    .wrap_top_i    (wrap_top),
    .wrap_bottom_i (wrap_bottom),
    .jump_taken_i  (jump_taken_s),
    .target_i      (instr[ADDR_W-1:0]),
    .advance_i     (complete_s),
    .pc_next_o     (pc_nxt_s)
  );

  // Next-state and execute logic; complete_s means the instruction retires
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    pins_out_d   = pins_out_q;
    pins_oe_d    = pins_oe_q;
    cnt_d        = cnt_q;
    complete_s   = 1'b0;
    jump_taken_s = 1'b0;
    if (restart) begin
      state_d = ST_EXEC;
      x_d     = '0;
      y_d     = '0;
      cnt_d   = '0;
    end else if (en) begin
      case (state_q)
        ST_EXEC: begin
          case (opcode_s)
            OP_JMP: begin
              complete_s = 1'b1;
              case (field_s)
                JC_ALWAYS: jump_taken_s = 1'b1;
                JC_X_ZERO: jump_taken_s = (x_q == '0);
                JC_X_DEC: begin
                  jump_taken_s = (x_q != '0);
                  x_d          = x_q - DATA_W'(1);
                end
                JC_Y_ZERO: jump_taken_s = (y_q == '0);
                JC_Y_DEC: begin
                  jump_taken_s = (y_q != '0);
                  y_d          = y_q - DATA_W'(1);
                end
                JC_X_NE_Y: jump_taken_s = (x_q != y_q);
                default:   jump_taken_s = 1'b0;
              endcase
            end
            OP_WAIT: begin
              if (wait_met_s) begin
                complete_s = 1'b1;
              end else begin
                state_d = ST_WAIT;
              end
            end
            OP_SET: begin
              complete_s = 1'b1;
              case (field_s)
                DST_PINS:    pins_out_d[4:0] = instr[4:0];
                DST_X:       x_d = DATA_W'(instr[4:0]);
                DST_Y:       y_d = DATA_W'(instr[4:0]);
                DST_PINDIRS: pins_oe_d[4:0] = instr[4:0];
                default:     x_d = x_q;
              endcase
            end
            OP_MOV: begin
              complete_s = 1'b1;
              case (field_s)
                DST_PINS: pins_out_d = mov_val_s[PIN_W-1:0];
                DST_X:    x_d = mov_val_s;
                DST_Y:    y_d = mov_val_s;
                default:  x_d = x_q;
              endcase
            end
            default: complete_s = 1'b1;
          endcase
        end
        ST_WAIT: begin
          if (wait_met_s) begin
            complete_s = 1'b1;
          end else begin
            complete_s = 1'b0;
          end
        end
        ST_DELAY: begin
          cnt_d = cnt_q - DELAY_W'(1);
          if (cnt_q == DELAY_W'(1)) begin
            state_d = ST_EXEC;
          end else begin
            state_d = ST_DELAY;
          end
        end
        default: state_d = ST_EXEC;
      endcase
      if (complete_s) begin
        if (delay_s != '0) begin
          state_d = ST_DELAY;
          cnt_d   = delay_s;
        end else begin
          state_d = ST_EXEC;
          cnt_d   = '0;
        end
      end else begin
        cnt_d = cnt_d;
      end
    end else begin
      state_d = state_q;
    end
    stalled_d = (state_d != ST_EXEC);
  end

  assign pc_d = restart ? wrap_bottom : pc_nxt_s;

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_EXEC;
      pc_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      pins_out_q <= '0;
      pins_oe_q  <= '0;
      cnt_q      <= '0;
      stalled_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      x_q        <= x_d;
      y_q        <= y_d;
      pins_out_q <= pins_out_d;
      pins_oe_q  <= pins_oe_d;
      cnt_q      <= cnt_d;
      stalled_q  <= stalled_d;
    end
  end

  assign pc       = pc_q;
  assign pins_out = pins_out_q;
  assign pins_oe  = pins_oe_q;
  assign stalled  = stalled_q;

endmodule

// File: doc/pio_sm_core.md
Name: pio_sm_core

Overview:
- Parametrised PIO state-machine execution core: fetches one 16-bit instruction per cycle by PC and executes it.
- Supports JMP (with conditions), WAIT, SET and MOV against scratch registers X/Y, output pins and pin directions; also handles per-instruction delay and a programmable wrap window.
- Sits between instruction memory (asynchronous read, addressed by pc) and the GPIO pad layer.
- IN, OUT, PUSH, PULL and IRQ execute as 1-cycle NOPs until the FIFO blocks exist.

Parameters:
- ADDR_W, 5: PC / jump-target width; instruction memory depth is 2**ADDR_W.
- DATA_W, 32: X/Y scratch register width; must be ≥ 8.
- PIN_W, 8: pin bus width; must be ≥ 5.
- DELAY_W, 5: delay field width, taken from instr[8+DELAY_W-1:8]; must be ≤ 5.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  execute enable; low freezes all state
- restart  in  1  synchronous restart (see Behaviour)
- wrap_top  in  ADDR_W  address of last instruction in wrap window
- wrap_bottom  in  ADDR_W  address jumped to after wrap_top
- instr  in  16  instruction at pc (combinational read)
- pins_in  in  PIN_W  sampled pin levels
- pc  out  ADDR_W  current program counter (registered)
- pins_out  out  PIN_W  output levels (registered)
- pins_oe  out  PIN_W  output enables (registered)
- stalled  out  1  high while in WAIT or DELAY state

Behaviour:
- Reset (async, rst=1): pc=0, X=0, Y=0, pins_out=0, pins_oe=0, delay counter=0, state=EXEC, stalled=0.
- Restart (restart=1 on a clock edge, overrides en and instr): pc=wrap_bottom, X=Y=0, delay=0, state=EXEC. pins_out/pins_oe are held.
- en=0: no register changes; stalled holds its value.
- Instruction encoding:
  - opcode = instr[15:13]: 000 JMP, 001 WAIT, 101 MOV, 111 SET; all others are NOP.
  - instr[12:8] = delay field.
- States:
  - EXEC: decode and execute instr in one cycle.
    - If the instruction completes and delay≠0: load counter=delay, go to DELAY.
    - WAIT with an unmet condition: go to WAIT; pc holds.
  - DELAY: counter decrements each enabled cycle; pc already advanced; at counter==1 return to EXEC.
  - WAIT: re-evaluate each cycle; when met, pc advances and the delay applies as in EXEC.
- Next PC when not jumping: pc==wrap_top → wrap_bottom; otherwise pc+1 mod 2**ADDR_W.
- A taken JMP ignores the wrap check.
- JMP: cond=instr[7:5], target=instr[ADDR_W-1:0].
  - 000 always.
  - 001 X==0.
  - 010 X!=0, post-decrement X (X-- happens whether or not taken; X=0 wraps to all-ones, not taken).
  - 011 Y==0.
  - 100 Y!=0, post-decrement Y (same rules as 010).
  - 101 X!=Y.
  - 110 and 111 never taken.
- WAIT: polarity=instr[7], pin index=instr[4:0] mod PIN_W.
  - Condition: pins_in[idx]==polarity, sampled in the current cycle.
  - Met in EXEC → behaves like a NOP (1 cycle).
- SET: dest=instr[7:5], data=instr[4:0].
  - 000: pins_out[4:0]=data.
  - 001: X=zero-extended data.
  - 010: Y=zero-extended data.
  - 100: pins_oe[4:0]=data.
  - Others: NOP.
  - Upper pin bits are unchanged.
- MOV: dest=instr[7:5], op=instr[4:3], src=instr[2:0].
  - src: 000 zero-extended pins_in; 001 X; 010 Y; 011 zero; others zero.
  - op: 00 none, 01 bitwise invert, 10 bit-reverse over DATA_W, 11 none.
  - dest: 000 pins_out=low PIN_W bits; 001 X; 010 Y; others NOP.
  - MOV X,X with invert is legal (reads old value).
- All writes are registered; the result is visible the cycle after EXEC.

Decomposition:
- Shared package pio_pkg:
  - opcode constants;
  - JMP condition codes;
  - SET / MOV destination codes;
  - MOV source and op codes;
  - state enum (EXEC, DELAY, WAIT).
- One sub-module, pio_pc_next: combinational next-PC from pc, wrap_top, wrap_bottom, jump_taken, target, advance; parametrised by ADDR_W.

Test Plan:
- Wrap: wrap_bottom=2, wrap_top=4, NOPs everywhere, en=1 → pc sequence 0,1,2,3,4,2,3,4,…
- Countdown loop:
  - Stimulus: SET X,3 at 0; JMP X-- to 1 at 1; then NOP at 2.
  - Required: pc visits 1 four times, then reaches 2 with X=all-ones (DATA_W=32: 0xFFFFFFFF).
- Delay: SET pins,5 with delay 3 at pc 0 → pins_out[4:0]=5 after 1 cycle; stalled high 3 cycles; pc=1 throughout; NOP at 1 executes on cycle 5.
- WAIT: WAIT polarity 1 on pin 2 while pins_in=0 for 6 cycles → pc frozen, stalled=1; pins_in[2]=1 → pc advances next cycle, stalled=0.
- MOV:
  - X=0x0000000F then MOV Y, bit-reverse X → Y=0xF0000000.
  - MOV X, invert null → X=0xFFFFFFFF.
  - MOV pins, X → pins_out=0xFF.
- Reset/restart mid-delay:
  - rst asserted during DELAY (asynchronous, mid-cycle) → all outputs zero immediately.
  - restart during WAIT with wrap_bottom=7 → pc=7 next edge, state EXEC, pins_out held.
